stage3_fc_ctrl: RTL and testbench
=================================

STAGE3_FC_CTRL -- requirements
Module: stage3_fc_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 48, number of pooled features per frame.
REQ-002 SHALL have parameter ADDR_BW, default 6, weight-address width; N_IN <= 2**ADDR_BW.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_feat_valid  input  1  pooled feature valid.
REQ-006 SHALL have port o_feat_ready  output  1  feature accepted when valid & ready.
REQ-007 SHALL have port o_w_addr  output  ADDR_BW  weight/feature index to the MAC array.
REQ-008 SHALL have port o_acc_en  output  1  MAC accumulate strobe.
REQ-009 SHALL have port o_acc_clr  output  1  MAC accumulator clear.
REQ-010 SHALL have port o_core_valid  output  1  drives bias-add core i_in_valid.
REQ-011 SHALL have port i_core_valid  input  1  bias-add core o_ot_valid.
REQ-012 SHALL have port i_core_result  input  CO*OUT_BW  bias-added channel results, channel 0 in the LSBs.
REQ-013 SHALL have port o_done, o_busy, o_err  output  1 each  frame-done pulse, busy level, sticky protocol error.
REQ-014 SHALL have port o_class  output  2  winning class; o_class_valid  output  1  one-cycle pulse.

Function
REQ-015 SHALL implement FSM IDLE, ACC, DRAIN, BIAS, WAIT, DONE.
REQ-016 o_feat_ready SHALL be 1 in IDLE and ACC only; o_acc_en SHALL equal i_feat_valid & o_feat_ready, combinationally.
REQ-017 o_w_addr SHALL equal the registered feature count, 0 for the first feature of a frame, incremented on each accept.
REQ-018 IDLE -> ACC on first accept; ACC -> DRAIN on the accept that makes count N_IN; count then returns to 0.
REQ-019 DRAIN SHALL last exactly 1 cycle, matching the 1-cycle MAC latency; then BIAS.
REQ-020 BIAS SHALL assert o_core_valid for exactly 1 cycle, then WAIT.
REQ-021 WAIT -> DONE when i_core_valid=1; WAIT holds indefinitely otherwise.
REQ-022 DONE SHALL last 1 cycle, asserting o_done and o_acc_clr; then IDLE. Accumulators are thus clear before the next frame.
REQ-023 o_busy SHALL be 1 in every state except IDLE.
REQ-024 i_core_valid outside WAIT SHALL be ignored for sequencing and SHALL set o_err, cleared only by reset.
REQ-025 A gap in i_feat_valid during ACC SHALL stall the count with no timeout; no feature loss.
REQ-026 With N_IN=1, the first accept SHALL go IDLE -> DRAIN directly.

Reset
REQ-027 On reset_n=0: state IDLE, count 0, o_err 0, o_class 0; o_done, o_core_valid, o_class_valid and o_acc_en SHALL be 0. o_acc_clr SHALL be 1 while reset is asserted.
REQ-028 Reset mid-frame SHALL abandon the frame, with no o_done or o_class_valid for it.

Configuration
REQ-029 Macro STAGE3_FC_ARGMAX_EN defined: in WAIT on i_core_valid, signed argmax over CO=3 channels SHALL be registered to o_class, with o_class_valid pulsing in the DONE cycle. Ties SHALL resolve to the lowest index.
REQ-030 Macro undefined: o_class SHALL be constant 0 and o_class_valid constant 0, with no comparator logic; ports remain.

Structure
REQ-031 Package stage3_fc_pkg SHALL hold CO=3, OUT_BW=16 and the FSM state enumeration.
REQ-032 Argmax SHALL be sub-module stage3_argmax3 (combinational), instantiated only under STAGE3_FC_ARGMAX_EN.

Verification
REQ-033 48 back-to-back features -> o_w_addr 0..47, 48 o_acc_en pulses, o_core_valid 2 cycles after the last accept, and o_done 1 cycle after i_core_valid.
REQ-034 Feature valid deasserted for 5 cycles at index 20 -> count holds at 20, ready stays 1, and the frame completes with 48 accepts.
REQ-035 Results {10,-3,10} with ARGMAX_EN -> o_class=0; {-5,7,2} -> o_class=1; macro off -> o_class_valid never 1.
REQ-036 i_core_valid pulsed in ACC -> o_err=1 and stays 1; the frame still completes normally.
REQ-037 reset_n low at feature 30 -> next frame starts at o_w_addr=0 and no stray o_done occurs.
REQ-038 i_core_valid withheld for 100 cycles -> FSM stays in WAIT, o_busy=1, and o_feat_ready=0.

Source files
------------

// File: rtl/stage3_fc_pkg.sv
// Shared constants and FSM state type for the stage-3 fully-connected controller.
package stage3_fc_pkg;

    localparam int CO       = 3;   // output channels (classes)
    localparam int OUT_BW   = 16;  // bias-added result width per channel
    localparam int CLASS_BW = 2;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        BIAS,
        WAIT,
        DONE
    } fc_state_t;

endpackage

// File: rtl/stage3_fc_ctrl_if.sv
// Feature-stream handshake between the pooled-feature source / MAC array and the FC controller.
interface stage3_fc_ctrl_if #(
    parameter int ADDR_BW = 6
);

    logic               i_feat_valid;
    logic               o_feat_ready;
    logic [ADDR_BW-1:0] o_w_addr;
    logic               o_acc_en;

    // Feature source / MAC side.
    modport master (
        output i_feat_valid,
        input  o_feat_ready,
        input  o_w_addr,
        input  o_acc_en
    );

    // Controller side.
    modport slave (
        input  i_feat_valid,
        output o_feat_ready,
        output o_w_addr,
        output o_acc_en
    );

endinterface

// File: rtl/stage3_argmax3.sv
// Combinational signed argmax over the CO=3 bias-added channel results; ties go to the lowest index.
module stage3_argmax3
    import stage3_fc_pkg::*;
(
    input  logic [CO*OUT_BW-1:0] result,
    output logic [CLASS_BW-1:0]  idx
);

    logic signed [OUT_BW-1:0] ch0, ch1, ch2;
    logic signed [OUT_BW-1:0] best_val;

    assign ch0 = result[0*OUT_BW +: OUT_BW];
    assign ch1 = result[1*OUT_BW +: OUT_BW];
    assign ch2 = result[2*OUT_BW +: OUT_BW];

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        best_val = ch0;
        idx      = 2'd0;
        // Strict '>' keeps the earlier channel on a tie.
        if (ch1 > best_val) begin
            best_val = ch1;
            idx      = 2'd1;
        end
        if (ch2 > best_val) begin
            best_val = ch2;
            idx      = 2'd2;
        end
    end

endmodule

// File: rtl/stage3_fc_ctrl.sv
// Stage-3 FC sequencer: counts N_IN features into the MAC array, fires the bias core, reports done.
// Optional argmax classification is enabled by defining STAGE3_FC_ARGMAX_EN.
module stage3_fc_ctrl
    import stage3_fc_pkg::*;
#(
    parameter int N_IN    = 48,
    parameter int ADDR_BW = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stage3_fc_ctrl_if.slave       feat,
    output logic                  o_acc_clr,
    output logic                  o_core_valid,
    input  logic                  i_core_valid,
    input  logic [CO*OUT_BW-1:0]  i_core_result,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err,
    output logic [CLASS_BW-1:0]   o_class,
    output logic                  o_class_valid
);

    localparam logic [ADDR_BW-1:0] LAST_IDX = ADDR_BW'(N_IN - 1);

    fc_state_t          state_q;
    logic [ADDR_BW-1:0] cnt_q;
    logic               feat_ready_q;
    logic               core_valid_q;
    logic               done_q;
    logic               acc_clr_q;
    logic               busy_q;
    logic               err_q;
    logic               accept;

    // Gated by reset_n so no accumulate strobe escapes while reset is held.
    assign accept = feat.i_feat_valid & feat_ready_q & reset_n;

    assign feat.o_feat_ready = feat_ready_q;
    assign feat.o_acc_en     = accept;
    assign feat.o_w_addr     = cnt_q;
    assign o_acc_clr         = acc_clr_q;
    assign o_core_valid      = core_valid_q;
    assign o_done            = done_q;
    assign o_busy            = busy_q;
    assign o_err             = err_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            feat_ready_q <= 1'b1;
            core_valid_q <= 1'b0;
            done_q       <= 1'b0;
            acc_clr_q    <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (i_core_valid && (state_q != WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE, ACC: begin
                    acc_clr_q <= 1'b0;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            cnt_q        <= '0;
                            state_q      <= DRAIN;
                            feat_ready_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + ADDR_BW'(1);
                            state_q <= ACC;
                        end
                    end
                end
                DRAIN: begin
                    // One cycle lets the final MAC product land before the bias add.
                    state_q      <= BIAS;
                    core_valid_q <= 1'b1;
                end
                BIAS: begin
                    state_q      <= WAIT;
                    core_valid_q <= 1'b0;
                end
                WAIT: begin
                    if (i_core_valid) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        acc_clr_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    acc_clr_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    feat_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef STAGE3_FC_ARGMAX_EN
    logic [CLASS_BW-1:0] argmax_idx;
    logic [CLASS_BW-1:0] class_q;
    logic                class_valid_q;

    stage3_argmax3 u_argmax (
        .result (i_core_result),
        .idx    (argmax_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            class_valid_q <= 1'b0;
            if ((state_q == WAIT) && i_core_valid) begin
                class_q       <= argmax_idx;
                class_valid_q <= 1'b1;
            end
        end
    end

    assign o_class       = class_q;
    assign o_class_valid = class_valid_q;
`else
    logic unused_core_result;

    assign unused_core_result = ^i_core_result;
    assign o_class            = '0;
    assign o_class_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_stage3_fc_ctrl.sv
// Directed self-checking bench for stage3_fc_ctrl; class checks follow STAGE3_FC_ARGMAX_EN.
module tb_stage3_fc_ctrl;
    import stage3_fc_pkg::*;

    localparam int N_IN    = 48;
    localparam int ADDR_BW = 6;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 o_acc_clr;
    logic                 o_core_valid;
    logic                 i_core_valid = 1'b0;
    logic [CO*OUT_BW-1:0] i_core_result = '0;
    logic                 o_done;
    logic                 o_busy;
    logic                 o_err;
    logic [CLASS_BW-1:0]  o_class;
    logic                 o_class_valid;

    int n_checks = 0;
    int n_errors = 0;
    int acc_pulses = 0;
    int done_pulses = 0;
    int clsv_pulses = 0;

    always #5 clk = ~clk;

    stage3_fc_ctrl_if #(.ADDR_BW(ADDR_BW)) feat_if ();

    stage3_fc_ctrl #(.N_IN(N_IN), .ADDR_BW(ADDR_BW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .feat          (feat_if.slave),
        .o_acc_clr     (o_acc_clr),
        .o_core_valid  (o_core_valid),
        .i_core_valid  (i_core_valid),
        .i_core_result (i_core_result),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_err         (o_err),
        .o_class       (o_class),
        .o_class_valid (o_class_valid)
    );

    always @(negedge clk) begin
        if (feat_if.o_acc_en === 1'b1) acc_pulses  <= acc_pulses + 1;
        if (o_done === 1'b1)           done_pulses <= done_pulses + 1;
        if (o_class_valid === 1'b1)    clsv_pulses <= clsv_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CO*OUT_BW-1:0] pack3(input int c0, input int c1, input int c2);
        return {c2[15:0], c1[15:0], c0[15:0]};
    endfunction

    task automatic send_feat(input int idx);
        feat_if.i_feat_valid = 1'b1;
        @(negedge clk);
        check("w_addr", feat_if.o_w_addr, idx);
        check("acc_en", feat_if.o_acc_en, 1);
        tick();
        feat_if.i_feat_valid = 1'b0;
    endtask

    // Entered one cycle after the last accept (DRAIN); leaves just after the edge into IDLE+1.
    task automatic finish_frame(input logic [CO*OUT_BW-1:0] res, input int exp_class,
                                input int wait_cycles, input int exp_err);
        int bad;
        @(negedge clk);
        check("drain_ready", feat_if.o_feat_ready, 0);
        check("drain_core_valid", o_core_valid, 0);
        check("drain_busy", o_busy, 1);
        tick();
        @(negedge clk);
        check("bias_core_valid", o_core_valid, 1);
        tick();
        bad = 0;
        repeat (wait_cycles) begin
            @(negedge clk);
            if (o_core_valid || !o_busy || feat_if.o_feat_ready || o_done) bad++;
            tick();
        end
        check("wait_hold", bad, 0);
        i_core_valid  = 1'b1;
        i_core_result = res;
        @(negedge clk);
        check("wait_done_low", o_done, 0);
        check("wait_busy", o_busy, 1);
        tick();
        i_core_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", o_done, 1);
        check("done_acc_clr", o_acc_clr, 1);
        check("done_err", o_err, exp_err);
`ifdef STAGE3_FC_ARGMAX_EN
        check("class_valid", o_class_valid, 1);
        check("class", o_class, exp_class);
`else
        check("class_valid_off", o_class_valid, 0);
        check("class_off", o_class, 0);
`endif
        tick();
        @(negedge clk);
        check("idle_done", o_done, 0);
        check("idle_busy", o_busy, 0);
        check("idle_ready", feat_if.o_feat_ready, 1);
        check("idle_acc_clr", o_acc_clr, 0);
        check("idle_addr", feat_if.o_w_addr, 0);
        check("idle_class_valid", o_class_valid, 0);
        tick();
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, d0, c0;
        feat_if.i_feat_valid = 1'b1;
        @(negedge clk);
        check("rst_acc_en", feat_if.o_acc_en, 0);
        check("rst_acc_clr", o_acc_clr, 1);
        check("rst_done", o_done, 0);
        check("rst_core_valid", o_core_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_addr", feat_if.o_w_addr, 0);
        check("rst_class", o_class, 0);
        check("rst_class_valid", o_class_valid, 0);
        feat_if.i_feat_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Frame A: back-to-back, short WAIT, {10,-3,10} -> class 0.
        a0 = acc_pulses; d0 = done_pulses;
        for (int i = 0; i < N_IN; i++) send_feat(i);
        finish_frame(pack3(10, -3, 10), 0, 3, 0);
        check("a_acc_count", acc_pulses - a0, N_IN);
        check("a_done_count", done_pulses - d0, 1);

        // Frame B: 5-cycle gap at index 20, core withheld 100 cycles, {-5,7,2} -> class 1.
        a0 = acc_pulses; d0 = done_pulses;
        for (int i = 0; i < N_IN; i++) begin
            if (i == 20) begin
                repeat (5) begin
                    @(negedge clk);
                    check("gap_addr", feat_if.o_w_addr, 20);
                    check("gap_ready", feat_if.o_feat_ready, 1);
                    check("gap_acc_en", feat_if.o_acc_en, 0);
                    tick();
                end
            end
            send_feat(i);
        end
        finish_frame(pack3(-5, 7, 2), 1, 100, 0);
        check("b_acc_count", acc_pulses - a0, N_IN);
        check("b_done_count", done_pulses - d0, 1);

        // Frame C: stray core valid during ACC sets sticky error; {1,2,3} -> class 2.
        a0 = acc_pulses; d0 = done_pulses;
        for (int i = 0; i < N_IN; i++) begin
            if (i == 10) i_core_valid = 1'b1;
            send_feat(i);
            i_core_valid = 1'b0;
            if (i == 10) begin
                @(negedge clk);
                check("err_set", o_err, 1);
                check("err_busy", o_busy, 1);
                tick();
            end
        end
        finish_frame(pack3(1, 2, 3), 2, 2, 1);
        check("c_acc_count", acc_pulses - a0, N_IN);
        check("c_done_count", done_pulses - d0, 1);

        // Reset at feature 30 abandons the frame.
        a0 = acc_pulses; d0 = done_pulses; c0 = clsv_pulses;
        for (int i = 0; i < 30; i++) send_feat(i);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_addr", feat_if.o_w_addr, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_acc_clr", o_acc_clr, 1);
        check("mid_rst_ready", feat_if.o_feat_ready, 1);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("mid_acc_count", acc_pulses - a0, 30);
        check("mid_no_done", done_pulses - d0, 0);
        check("mid_no_class_valid", clsv_pulses - c0, 0);

        // Frame D: fresh frame from address 0, tie {-7,4,4} -> class 1.
        a0 = acc_pulses; d0 = done_pulses;
        for (int i = 0; i < N_IN; i++) send_feat(i);
        finish_frame(pack3(-7, 4, 4), 1, 1, 0);
        check("d_acc_count", acc_pulses - a0, N_IN);
        check("d_done_count", done_pulses - d0, 1);

`ifdef STAGE3_FC_ARGMAX_EN
        check("class_valid_total", clsv_pulses, 4);
`else
        check("class_valid_never", clsv_pulses, 0);
`endif
        check("done_total", done_pulses, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
